alu_seq: RTL



---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and flags
// ALU_SEQ_MUL_EN enables the iterative shift-add multiplier for opcode 1110.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             illegal_op
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHLU = 4'b0011;
  localparam logic [3:0] OP_SHRU = 4'b0100;
  localparam logic [3:0] OP_SHLS = 4'b0101;
  localparam logic [3:0] OP_SHRS = 4'b0110;
  localparam logic [3:0] OP_LT   = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_NEQ  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_LTS  = 4'b1111;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic             ill_c;
  logic             accept;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (op)
      OP_ADD: begin
        res_c   = sum_ext[WIDTH-1:0];
        carry_c = sum_ext[WIDTH];
        ovf_c   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      // The extra bit of the unsigned difference is exactly the borrow a<b.
      OP_SUB: begin
        res_c   = diff_ext[WIDTH-1:0];
        carry_c = diff_ext[WIDTH];
        ovf_c   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_SHLU, OP_SHLS: res_c = a << shamt;
      OP_SHRU:          res_c = a >> shamt;
      OP_SHRS:          res_c = $signed(a) >>> shamt;
      OP_LT:            res_c = {{(WIDTH-1){1'b0}}, a < b};
      OP_EQ:            res_c = {{(WIDTH-1){1'b0}}, a == b};
      OP_NEQ:           res_c = {{(WIDTH-1){1'b0}}, a != b};
      OP_AND:           res_c = a & b;
      OP_OR:            res_c = a | b;
      OP_XOR:           res_c = a ^ b;
      OP_NOR:           res_c = ~(a | b);
      OP_LTS:           res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:           ;
`endif
      default:          ill_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic             is_mul;

  assign is_mul   = (op == OP_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      result        <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
`endif
    end else begin
      // A load below overrides this, so consume+accept keeps out_valid high.
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= BUSY;
            end else
`endif
            begin
              result        <= res_c;
              zero_flag     <= (res_c == '0);
              carry_flag    <= carry_c;
              overflow_flag <= ovf_c;
              illegal_op    <= ill_c;
              out_valid     <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            result        <= acc_next;
            zero_flag     <= (acc_next == '0);
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            illegal_op    <= 1'b0;
            out_valid     <= 1'b1;
            cnt           <= '0;
            state         <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
